imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, flow-controlled RISC-V immediate generator; successor to the combinational extender. Takes a 32-bit instruction word plus an immediate-format select and returns the decoded immediate sign- or zero-extended to XLEN. It adds shift-amount and CSR-zimm formats, carries a sideband tag, and has a valid/ready handshake with a 2-entry skid buffer. It sits between fetch/decode and execute, so it can be backpressured at full throughput without a combinational ready path.

## Interface
- XLEN, 32, immediate output width; legal values 32 and 64.
- TAG_W, 5, width of the sideband tag carried with each instruction (e.g. rd or ROB index).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  input entry valid.
- in_ready  out  1  block can accept an entry.
- inst  in  32  instruction word.
- extend_sel  in  3  immediate format select.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  consumer accepts the output entry.
- imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag belonging to imm.

## Operation
- Formats (extend_sel). "sext" means replicate inst[31] up to XLEN.
  - 000 NONE: imm = 0.
  - 001 I: sext(inst[31:20]).
  - 010 SHAMT: zero-extend inst[24:20] when XLEN=32; zero-extend inst[25:20] when XLEN=64.
  - 011 S: sext({inst[31:25], inst[11:7]}).
  - 100 B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 101 U: sext({inst[31:12], 12'b0}). This is plain placement at XLEN=32 and sign-extension at XLEN=64.
  - 110 J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 111 ZIMM: zero-extend inst[19:15].
- Decode is combinational on the input side. Only the decoded imm and the tag are stored, never inst.
- Storage:
  - Output register (OUT: out_valid, imm, out_tag).
  - Skid register (SKD: skd_valid, skd_imm, skd_tag).
- Input transfer (in_valid & in_ready at an edge):
  - Goes into OUT if OUT is empty, or if OUT is being drained this cycle (out_ready) and SKD is empty.
  - Otherwise goes into SKD.
- Output transfer (out_valid & out_ready at an edge):
  - If SKD is valid, SKD moves into OUT and SKD empties. A simultaneous input transfer is then impossible, because in_ready was 0.
  - Else, if an input transfer occurs, it loads OUT.
  - Else OUT empties.
- in_ready = !skd_valid. It is a registered-state function only, with no combinational path from out_ready.
- Occupancy is 0, 1 or 2 and never exceeds 2. Order is strictly FIFO.
- While out_valid=1 and out_ready=0, imm and out_tag hold stable.
- flush:
  - Next cycle: out_valid=0, skd_valid=0, in_ready=1.
  - Any input presented in the flush cycle is dropped.
  - flush has priority over all transfers; rst has priority over flush.

## Timing
- Reset values: out_valid=0, imm=0, out_tag=0, skd_valid=0, in_ready=1.
  - Applies from the first edge with rst=1 and holds while rst is high.
- Latency: an input accepted at edge N appears at out_valid/imm by edge N+1, provided OUT was empty or draining.
- Throughput: 1 entry/cycle while out_ready=1 continuously.
- Backpressure:
  - out_ready low with OUT full → the next accepted entry goes to SKD.
  - After that, in_ready=0 from the following cycle until SKD drains.
- Recovery: after out_ready rises, in_ready returns to 1 one cycle later (SKD→OUT at that edge).
- Simultaneous input accept and output accept with SKD empty: OUT is replaced by the new entry with no bubble.
- Reset or flush mid-stream: buffered entries are lost. No partial output appears.

## Test plan
- I and B decode, XLEN=32, out_ready=1:
  - inst=0xFFF00093, sel=001, tag=3 → next cycle imm=0xFFFFFFFF, out_tag=3.
  - inst=0xFE000EE3, sel=100 → imm=0xFFFFFFFC.
- U, SHAMT and ZIMM at XLEN=64:
  - inst=0x800000B7, sel=101 → imm=0xFFFFFFFF80000000.
  - inst=0x03F01013, sel=010 → imm=63.
  - inst=0x000FD073, sel=111 → imm=31.
- Backpressure: stream 4 tagged entries (tags 0..3) with out_ready=0 for 3 cycles, then 1.
  - Required: in_ready drops after 2 accepts.
  - imm/out_tag stay stable while stalled.
  - Outputs emerge in tag order 0,1,2,3 with none lost or duplicated.
- Full throughput: random out_ready 50%, random valid inputs, 1000 entries.
  - Required: every entry matches a reference decode in order.
  - Occupancy never exceeds 2.
  - in_ready never depends combinationally on out_ready.
- Flush with 2 buffered entries plus in_valid=1 in the same cycle.
  - Next cycle: out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Reset:
  - rst during a stall with OUT and SKD full → outputs reach the reset values above.
  - The first post-reset input appears one cycle after it is accepted.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a valid/ready
// handshake. The immediate is decoded combinationally from the incoming
// instruction. Only the decoded value and its tag are stored, in a 2-entry
// skid buffer (OUT + SKD). Because in_ready depends only on stored state,
// the consumer can stall at full rate without a combinational ready path.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       extend_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'b000;
  localparam logic [2:0] FMT_I     = 3'b001;
  localparam logic [2:0] FMT_SHAMT = 3'b010;
  localparam logic [2:0] FMT_S     = 3'b011;
  localparam logic [2:0] FMT_B     = 3'b100;
  localparam logic [2:0] FMT_U     = 3'b101;
  localparam logic [2:0] FMT_J     = 3'b110;
  localparam logic [2:0] FMT_ZIMM  = 3'b111;

  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  skd_imm;
  logic [TAG_W-1:0] skd_tag;
  logic             skd_valid;
  logic             in_xfer;
  logic             out_xfer;
  logic             unused_opcode;

  // The opcode field never contributes to any immediate format.
  assign unused_opcode = ^inst[6:0];

  // SKD can only fill while OUT is full, so SKD valid means occupancy 2.
  assign in_ready = !skd_valid;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Decode the immediate for the incoming instruction. Signed casts do the sign extension.
  always_comb begin
    dec_imm = '0;
    case (extend_sel)
      FMT_NONE:  dec_imm = '0;
      FMT_I:     dec_imm = XLEN'($signed(inst[31:20]));
      FMT_SHAMT: begin
        if (XLEN == 64) dec_imm[5:0] = inst[25:20];
        else            dec_imm[4:0] = inst[24:20];
      end
      FMT_S:     dec_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      FMT_B:     dec_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      FMT_U:     dec_imm = XLEN'($signed({inst[31:12], 12'h000}));
      FMT_J:     dec_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      FMT_ZIMM:  dec_imm[4:0] = inst[19:15];
      default:   dec_imm = '0;
    endcase
  end

  // OUT/SKD update. Reset beats flush, and flush beats every transfer. SKD
  // always drains into OUT first, which keeps the order strictly FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      imm       <= '0;
      out_tag   <= '0;
      skd_valid <= 1'b0;
      skd_imm   <= '0;
      skd_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skd_valid <= 1'b0;
    end else if (out_xfer) begin
      if (skd_valid) begin
        imm       <= skd_imm;
        out_tag   <= skd_tag;
        skd_valid <= 1'b0;
      end else if (in_xfer) begin
        imm     <= dec_imm;
        out_tag <= in_tag;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        imm       <= dec_imm;
        out_tag   <= in_tag;
      end else begin
        skd_valid <= 1'b1;
        skd_imm   <= dec_imm;
        skd_tag   <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives one stimulus stream into an XLEN=32 instance and
// an XLEN=64 instance. Both instances are checked against a queue-based
// FIFO model and an arithmetic immediate reference.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [4:0]  tag;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [2:0]  extend_sel = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  out_tag32, out_tag64;

  int total = 0;
  int bad = 0;
  bit modelKnown = 1'b0;
  entry_t q[$];
  logic [4:0] obsTags[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) d32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .extend_sel(extend_sel), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .imm(imm32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) d64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .extend_sel(extend_sel), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm(imm64), .out_tag(out_tag64)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  // Reference immediate. Each field is read as an unsigned number, and
  // 2^width is subtracted when the sign bit is set. Narrow results are truncated to 32 bits.
  function automatic logic [63:0] refDecode(input logic [31:0] i, input logic [2:0] s, input bit wide);
    longint v;
    logic [63:0] r;
    v = 0;
    case (s)
      3'd1: begin v = longint'(i[31:20]); if (i[31]) v = v - 4096; end
      3'd2: v = wide ? longint'(i[25:20]) : longint'(i[24:20]);
      3'd3: begin v = longint'({i[31:25], i[11:7]}); if (i[31]) v = v - 4096; end
      3'd4: begin v = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}); if (i[31]) v = v - 8192; end
      3'd5: begin v = longint'({i[31:12], 12'h000}); if (i[31]) v = v - (longint'(1) << 32); end
      3'd6: begin v = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}); if (i[31]) v = v - 2097152; end
      3'd7: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    r = v;
    if (!wide) r = {32'h0, r[31:0]};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle. Inputs are driven at the negedge. Outputs are then
  // checked against the model. The model then steps to mirror the coming posedge.
  task automatic applyStimulus(input bit v, input logic [31:0] i, input logic [2:0] s,
                               input logic [4:0] t, input bit ordy, input bit fl,
                               input bit rs, output bit acc);
    entry_t e;
    bit outFire;
    @(negedge clk);
    in_valid = v; inst = i; extend_sel = s; in_tag = t;
    out_ready = ordy; flush = fl; rst = rs;
    #1;
    acc = 1'b0;
    if (modelKnown) begin
      checkOutput("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
      checkOutput("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
      checkOutput("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      checkOutput("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        checkOutput("imm32", {32'h0, imm32}, refDecode(q[0].inst, q[0].sel, 1'b0));
        checkOutput("imm64", imm64, refDecode(q[0].inst, q[0].sel, 1'b1));
        checkOutput("tag32", 64'(out_tag32), 64'(q[0].tag));
        checkOutput("tag64", 64'(out_tag64), 64'(q[0].tag));
      end
      out_ready = !ordy;
      #1;
      checkOutput("in_ready_comb", 64'(in_ready32), 64'(q.size() < 2));
      out_ready = ordy;
      if (out_valid32 && ordy && !fl && !rs) obsTags.push_back(out_tag32);
    end
    if (rs) begin
      q.delete();
      modelKnown = 1'b1;
    end else if (fl) begin
      q.delete();
    end else if (modelKnown) begin
      outFire = (q.size() > 0) && ordy;
      acc = v && (q.size() < 2);
      if (outFire) void'(q.pop_front());
      if (acc) begin
        e.inst = i; e.sel = s; e.tag = t;
        q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    bit acc;
    int sent;
    int cyc;

    // Reset
    applyStimulus(0, '0, 3'd0, 5'd0, 0, 0, 1, acc);
    applyStimulus(0, '0, 3'd0, 5'd0, 0, 0, 1, acc);
    #1;
    checkOutput("rst_imm32", {32'h0, imm32}, 64'h0);
    checkOutput("rst_imm64", imm64, 64'h0);
    checkOutput("rst_tag", 64'(out_tag32), 64'h0);
    checkOutput("rst_in_ready", 64'(in_ready32), 64'h1);
    applyStimulus(0, '0, 3'd0, 5'd0, 1, 0, 0, acc);

    // Directed decodes with out_ready held high
    applyStimulus(1, 32'hFFF00093, 3'b001, 5'd3, 1, 0, 0, acc);
    #1;
    checkOutput("I_imm32", {32'h0, imm32}, 64'hFFFFFFFF);
    checkOutput("I_tag", 64'(out_tag32), 64'd3);
    applyStimulus(1, 32'hFE000EE3, 3'b100, 5'd4, 1, 0, 0, acc);
    #1;
    checkOutput("B_imm32", {32'h0, imm32}, 64'hFFFFFFFC);
    applyStimulus(1, 32'h800000B7, 3'b101, 5'd5, 1, 0, 0, acc);
    #1;
    checkOutput("U_imm64", imm64, 64'hFFFFFFFF80000000);
    checkOutput("U_imm32", {32'h0, imm32}, 64'h80000000);
    applyStimulus(1, 32'h03F01013, 3'b010, 5'd6, 1, 0, 0, acc);
    #1;
    checkOutput("SHAMT_imm64", imm64, 64'd63);
    checkOutput("SHAMT_imm32", {32'h0, imm32}, 64'd31);
    applyStimulus(1, 32'h000FD073, 3'b111, 5'd7, 1, 0, 0, acc);
    #1;
    checkOutput("ZIMM_imm64", imm64, 64'd31);
    applyStimulus(0, '0, 3'd0, 5'd0, 1, 0, 0, acc);

    // Backpressure: tags 0..3 with out_ready low for the first 3 cycles
    obsTags.delete();
    sent = 0;
    cyc = 0;
    while ((sent < 4 || q.size() > 0) && cyc < 40) begin
      applyStimulus(sent < 4, $urandom, 3'(sent + 1), 5'(sent), cyc >= 3, 0, 0, acc);
      if (cyc == 1) begin
        #1;
        checkOutput("bp_in_ready_low", 64'(in_ready32), 64'h0);
      end
      if (acc) sent++;
      cyc++;
    end
    checkOutput("bp_timeout", 64'(cyc < 40), 64'h1);
    checkOutput("bp_count", 64'(obsTags.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (k < obsTags.size()) checkOutput("bp_order", 64'(obsTags[k]), 64'(k));

    // Random traffic: 1000 accepted entries with 50% out_ready
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 10000) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, 0, acc);
      if (acc) sent++;
      cyc++;
    end
    checkOutput("rand_timeout", 64'(sent), 64'd1000);
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      applyStimulus(0, '0, 3'd0, 5'd0, 1, 0, 0, acc);
      cyc++;
    end
    checkOutput("drain", 64'(q.size()), 64'd0);

    // Flush with two buffered entries plus an input in the same cycle
    applyStimulus(1, 32'h00100093, 3'b001, 5'd10, 0, 0, 0, acc);
    applyStimulus(1, 32'h00200093, 3'b001, 5'd11, 0, 0, 0, acc);
    obsTags.delete();
    applyStimulus(1, 32'h00300093, 3'b001, 5'd20, 1, 1, 0, acc);
    #1;
    checkOutput("flush_out_valid", 64'(out_valid32), 64'h0);
    checkOutput("flush_in_ready", 64'(in_ready32), 64'h1);
    for (int k = 0; k < 3; k++) applyStimulus(0, '0, 3'd0, 5'd0, 1, 0, 0, acc);
    checkOutput("flush_dropped", 64'(obsTags.size()), 64'd0);

    // Reset while stalled with OUT and SKD full
    applyStimulus(1, 32'h12345093, 3'b001, 5'd12, 0, 0, 0, acc);
    applyStimulus(1, 32'h54321093, 3'b011, 5'd13, 0, 0, 0, acc);
    applyStimulus(0, '0, 3'd0, 5'd0, 0, 0, 0, acc);
    applyStimulus(0, '0, 3'd0, 5'd0, 0, 0, 1, acc);
    #1;
    checkOutput("rst2_out_valid", 64'(out_valid32), 64'h0);
    checkOutput("rst2_in_ready", 64'(in_ready32), 64'h1);
    checkOutput("rst2_imm64", imm64, 64'h0);
    checkOutput("rst2_tag", 64'(out_tag64), 64'h0);
    applyStimulus(1, 32'hFFF00093, 3'b001, 5'd9, 0, 0, 0, acc);
    #1;
    checkOutput("post_rst_valid", 64'(out_valid32), 64'h1);
    checkOutput("post_rst_imm32", {32'h0, imm32}, 64'hFFFFFFFF);
    checkOutput("post_rst_tag", 64'(out_tag32), 64'd9);
    applyStimulus(0, '0, 3'd0, 5'd0, 1, 0, 0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
